obi_mailbox_fifo: RTL and testbench

Parametrised multi-entry mailbox between two OBI managers in core-v-mini-mcu: a writer side pushes words, a reader side pops them, both through word-addressed OBI slave ports. It replaces single-word, single-shot transfer with a DEPTH-entry FIFO, status readback on both ports, back-pressure through gnt, and an optional not-empty interrupt. It sits on the system bus between, for example, a host/serial-link bridge and the core.

---
 rtl/mailbox_fifo_pkg.sv | 15 +
 rtl/mailbox_fifo_core.sv | 60 ++++++
 rtl/obi_mailbox_fifo.sv | 170 +++++++++++++++++
 tb/tb_obi_mailbox_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_fifo_pkg.sv
// Shared constants for the OBI mailbox FIFO: register offsets (address bits
// [3:2]) and bit positions inside the STATUS word.
package mailbox_fifo_pkg;

  typedef logic [1:0] offs_t;

  localparam offs_t DATA_OFFS   = 2'b00;
  localparam offs_t STATUS_OFFS = 2'b01;

  localparam int EMPTY_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int IRQ_BIT   = 2;
  localparam int COUNT_LSB = 8;

endpackage : mailbox_fifo_pkg

// File: rtl/mailbox_fifo_core.sv
// Storage, pointers and occupancy count for the mailbox FIFO. The head word
// is presented combinationally on data_o so a pop can capture it at grant.
// Storage is deliberately not reset; only pointers and count are.
module mailbox_fifo_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PW         = $clog2(DEPTH),
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;

  // Write the pushed word into the slot at the write pointer.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  // Advance pointers independently; power-of-two depth makes them wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (push_i) r_wrPtr <= r_wrPtr + PW'(1);
      if (pop_i)  r_rdPtr <= r_rdPtr + PW'(1);
    end
  end

  // Track occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (push_i && !pop_i) begin
      r_count <= r_count + CW'(1);
    end else if (pop_i && !push_i) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign data_o  = r_mem[r_rdPtr];
  assign count_o = r_count;
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);

endmodule : mailbox_fifo_core

// File: rtl/obi_mailbox_fifo.sv
// OBI mailbox FIFO: the writer port pushes words, the reader port pops them.
// Offsets 0x0 DATA, 0x4 STATUS, 0x8/0xC read as zero. Grants are
// combinational; each grant yields one registered rvalid the next cycle.
// Optional feature: define MAILBOX_FIFO_IRQ_EN for a level not-empty irq.
module obi_mailbox_fifo
  import mailbox_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  writer_req_i,
  output logic                  writer_gnt_o,
  output logic                  writer_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] writer_addr_i,
  input  logic                  writer_we_i,
  input  logic [3:0]            writer_be_i,
  input  logic [DATA_WIDTH-1:0] writer_wdata_i,
  output logic [DATA_WIDTH-1:0] writer_rdata_o,
  input  logic                  reader_req_i,
  output logic                  reader_gnt_o,
  output logic                  reader_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] reader_addr_i,
  input  logic                  reader_we_i,
  input  logic [3:0]            reader_be_i,
  input  logic [DATA_WIDTH-1:0] reader_wdata_i,
  output logic [DATA_WIDTH-1:0] reader_rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  irq_o
);

  localparam int CW = $clog2(DEPTH + 1);

  offs_t                 w_wrOffs;
  offs_t                 w_rdOffs;
  logic                  w_wrPushReq;
  logic                  w_rdPopReq;
  logic                  w_wrGnt;
  logic                  w_rdGnt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_irqBit;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_headData;
  logic [DATA_WIDTH-1:0] w_beMask;
  logic [DATA_WIDTH-1:0] w_pushData;
  logic [DATA_WIDTH-1:0] w_statusWord;
  logic [DATA_WIDTH-1:0] w_wrRespData;
  logic [DATA_WIDTH-1:0] w_rdRespData;
  logic                  w_unused;

  logic                  r_wrRvalid;
  logic                  r_rdRvalid;
  logic [DATA_WIDTH-1:0] r_wrRdata;
  logic [DATA_WIDTH-1:0] r_rdRdata;

  assign w_wrOffs = writer_addr_i[3:2];
  assign w_rdOffs = reader_addr_i[3:2];

  // Only DATA pushes and DATA pops can stall; everything else is granted.
  assign w_wrPushReq = writer_req_i && writer_we_i && (w_wrOffs == DATA_OFFS);
  assign w_rdPopReq  = reader_req_i && !reader_we_i && (w_rdOffs == DATA_OFFS);
  assign w_wrGnt     = rst_ni && writer_req_i && !(w_wrPushReq && w_full);
  assign w_rdGnt     = rst_ni && reader_req_i && !(w_rdPopReq && w_empty);
  assign w_push      = w_wrGnt && w_wrPushReq;
  assign w_pop       = w_rdGnt && w_rdPopReq;

  // Disabled byte lanes are stored as zero.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_beMask
    assign w_beMask[gi] = writer_be_i[(gi / 8) % 4];
  end
  assign w_pushData = writer_wdata_i & w_beMask;

  mailbox_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_pushData),
    .data_o  (w_headData),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifdef MAILBOX_FIFO_IRQ_EN
  logic r_irq;

  // Level interrupt following count != 0 with one cycle of latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_count != '0);
    end
  end

  assign w_irqBit = r_irq;
`else
  assign w_irqBit = 1'b0;
`endif

  // Assemble STATUS from the pre-update count of the grant cycle.
  always_comb begin
    w_statusWord                     = '0;
    w_statusWord[EMPTY_BIT]          = w_empty;
    w_statusWord[FULL_BIT]           = w_full;
    w_statusWord[IRQ_BIT]            = w_irqBit;
    w_statusWord[COUNT_LSB +: CW]    = w_count;
  end

  // Select the response word each port returns for the access being granted.
  always_comb begin
    w_wrRespData = '0;
    w_rdRespData = '0;
    if (!writer_we_i && (w_wrOffs == STATUS_OFFS)) begin
      w_wrRespData = w_statusWord;
    end
    if (w_pop) begin
      w_rdRespData = w_headData;
    end else if (!reader_we_i && (w_rdOffs == STATUS_OFFS)) begin
      w_rdRespData = w_statusWord;
    end
  end

  // Writer response: rvalid mirrors last cycle's grant, rdata zero otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrRvalid <= 1'b0;
      r_wrRdata  <= '0;
    end else begin
      r_wrRvalid <= w_wrGnt;
      r_wrRdata  <= w_wrGnt ? w_wrRespData : '0;
    end
  end

  // Reader response: pop data is captured here at grant time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdRvalid <= 1'b0;
      r_rdRdata  <= '0;
    end else begin
      r_rdRvalid <= w_rdGnt;
      r_rdRdata  <= w_rdGnt ? w_rdRespData : '0;
    end
  end

  assign writer_gnt_o    = w_wrGnt;
  assign reader_gnt_o    = w_rdGnt;
  assign writer_rvalid_o = r_wrRvalid;
  assign reader_rvalid_o = r_rdRvalid;
  assign writer_rdata_o  = r_wrRdata;
  assign reader_rdata_o  = r_rdRdata;
  assign full_o          = w_full;
  assign empty_o         = w_empty;
  assign irq_o           = w_irqBit;

  assign w_unused = ^{writer_addr_i[ADDR_WIDTH-1:4], writer_addr_i[1:0],
                      reader_addr_i[ADDR_WIDTH-1:4], reader_addr_i[1:0],
                      reader_be_i, reader_wdata_i};

endmodule : obi_mailbox_fifo

// File: tb/tb_obi_mailbox_fifo.sv
// Directed testbench for obi_mailbox_fifo (DEPTH=4). Inputs change 1ns after
// the rising edge; grants are checked 1ns later, registered outputs right
// after the edge.
module tb_obi_mailbox_fifo;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

`ifdef MAILBOX_FIFO_IRQ_EN
  localparam logic [31:0] IRQ_STATUS = 32'h0000_0004;
`else
  localparam logic [31:0] IRQ_STATUS = 32'h0000_0000;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          writer_req_i, writer_gnt_o, writer_rvalid_o, writer_we_i;
  logic [AW-1:0] writer_addr_i;
  logic [3:0]    writer_be_i;
  logic [DW-1:0] writer_wdata_i, writer_rdata_o;
  logic          reader_req_i, reader_gnt_o, reader_rvalid_o, reader_we_i;
  logic [AW-1:0] reader_addr_i;
  logic [3:0]    reader_be_i;
  logic [DW-1:0] reader_wdata_i, reader_rdata_o;
  logic          full_o, empty_o, irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  obi_mailbox_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .writer_req_i    (writer_req_i),
    .writer_gnt_o    (writer_gnt_o),
    .writer_rvalid_o (writer_rvalid_o),
    .writer_addr_i   (writer_addr_i),
    .writer_we_i     (writer_we_i),
    .writer_be_i     (writer_be_i),
    .writer_wdata_i  (writer_wdata_i),
    .writer_rdata_o  (writer_rdata_o),
    .reader_req_i    (reader_req_i),
    .reader_gnt_o    (reader_gnt_o),
    .reader_rvalid_o (reader_rvalid_o),
    .reader_addr_i   (reader_addr_i),
    .reader_we_i     (reader_we_i),
    .reader_be_i     (reader_be_i),
    .reader_wdata_i  (reader_wdata_i),
    .reader_rdata_o  (reader_rdata_o),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .irq_o           (irq_o)
  );

  task automatic setWriter(input logic req, input logic we, input logic [1:0] offs,
                           input logic [3:0] be, input logic [31:0] data);
    writer_req_i   = req;
    writer_we_i    = we;
    writer_addr_i  = {28'h0, offs, 2'b00};
    writer_be_i    = be;
    writer_wdata_i = data;
  endtask

  task automatic setReader(input logic req, input logic we, input logic [1:0] offs);
    reader_req_i   = req;
    reader_we_i    = we;
    reader_addr_i  = {28'h0, offs, 2'b00};
    reader_be_i    = 4'hF;
    reader_wdata_i = 32'h5555_5555;
  endtask

  task automatic nextCycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    setWriter(0, 0, 0, 0, 0);
    setReader(0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    setWriter(1, 1, 0, 4'hF, 32'h1234);
    settle;
    checks++; if (writer_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0", writer_gnt_o); end
    checks++; if (writer_rvalid_o !== 1'b0 || reader_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b%b want 00", writer_rvalid_o, reader_rvalid_o); end
    checks++; if (reader_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", reader_rdata_o); end
    checks++; if ({full_o, empty_o, irq_o} !== 3'b010) begin errors++; $display("[TB] FAIL reset_flags: full/empty/irq got %b want 010", {full_o, empty_o, irq_o}); end
    setWriter(0, 0, 0, 0, 0);
    settle;
    rst_ni = 1'b1;
    nextCycle;
  endtask

  task automatic test_fill_and_stall;
    for (int i = 0; i < 4; i++) begin
      setWriter(1, 1, 0, 4'hF, 32'hA0 + i);
      settle;
      checks++; if (writer_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL fill_gnt[%0d]: got %b want 1", i, writer_gnt_o); end
      nextCycle;
      checks++; if (writer_rvalid_o !== 1'b1 || writer_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL fill_rsp[%0d]: rvalid %b rdata %h want 1/0", i, writer_rvalid_o, writer_rdata_o); end
    end
    checks++; if (full_o !== 1'b1 || empty_o !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: full %b empty %b want 1/0", full_o, empty_o); end
    setWriter(1, 1, 0, 4'hF, 32'hA4);
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++; if (writer_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_gnt[%0d]: got %b want 0", i, writer_gnt_o); end
      nextCycle;
      checks++; if (writer_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_rvalid[%0d]: got %b want 0", i, writer_rvalid_o); end
    end
    setWriter(0, 0, 0, 0, 0);
  endtask

  task automatic test_drain;
    for (int i = 0; i < 4; i++) begin
      setReader(1, 0, 0);
      settle;
      checks++; if (reader_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL drain_gnt[%0d]: got %b want 1", i, reader_gnt_o); end
      nextCycle;
      checks++; if (reader_rvalid_o !== 1'b1 || reader_rdata_o !== 32'hA0 + i) begin errors++; $display("[TB] FAIL drain_data[%0d]: rvalid %b rdata %h want 1/%h", i, reader_rvalid_o, reader_rdata_o, 32'hA0 + i); end
    end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: empty %b full %b want 1/0", empty_o, full_o); end
    settle;
    checks++; if (reader_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL underflow_gnt: got %b want 0", reader_gnt_o); end
    nextCycle;
    checks++; if (reader_rvalid_o !== 1'b0 || reader_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL underflow_rsp: rvalid %b rdata %h want 0/0", reader_rvalid_o, reader_rdata_o); end
    setReader(0, 0, 0);
  endtask

  task automatic test_full_contention;
    for (int i = 0; i < 4; i++) begin
      setWriter(1, 1, 0, 4'hF, 32'hC0 + i);
      nextCycle;
    end
    setWriter(1, 1, 0, 4'hF, 32'hC4);
    setReader(1, 0, 0);
    settle;
    checks++; if (writer_gnt_o !== 1'b0 || reader_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL fullboth_gnt: wr %b rd %b want 0/1", writer_gnt_o, reader_gnt_o); end
    nextCycle;
    setReader(0, 0, 0);
    checks++; if (reader_rdata_o !== 32'hC0) begin errors++; $display("[TB] FAIL fullboth_pop: got %h want c0", reader_rdata_o); end
    settle;
    checks++; if (writer_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL fullboth_retry_gnt: got %b want 1", writer_gnt_o); end
    nextCycle;
    setWriter(0, 0, 0, 0, 0);
    checks++; if (full_o !== 1'b1) begin errors++; $display("[TB] FAIL fullboth_full: got %b want 1", full_o); end
    for (int i = 0; i < 4; i++) begin
      setReader(1, 0, 0);
      nextCycle;
      checks++; if (reader_rdata_o !== 32'hC1 + i) begin errors++; $display("[TB] FAIL fullboth_drain[%0d]: got %h want %h", i, reader_rdata_o, 32'hC1 + i); end
    end
    setReader(0, 0, 0);
  endtask

  task automatic test_empty_contention;
    setWriter(1, 1, 0, 4'hF, 32'hE5);
    setReader(1, 0, 0);
    settle;
    checks++; if (writer_gnt_o !== 1'b1 || reader_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL emptyboth_gnt: wr %b rd %b want 1/0", writer_gnt_o, reader_gnt_o); end
    nextCycle;
    setWriter(0, 0, 0, 0, 0);
    checks++; if (reader_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL emptyboth_rvalid: got %b want 0", reader_rvalid_o); end
    settle;
    checks++; if (reader_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL emptyboth_retry_gnt: got %b want 1", reader_gnt_o); end
    nextCycle;
    setReader(0, 0, 0);
    checks++; if (reader_rvalid_o !== 1'b1 || reader_rdata_o !== 32'hE5) begin errors++; $display("[TB] FAIL emptyboth_pop: rvalid %b rdata %h want 1/e5", reader_rvalid_o, reader_rdata_o); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      setWriter(1, 1, 0, 4'hF, 32'hD0 + i);
      nextCycle;
    end
    setWriter(1, 1, 0, 4'hF, 32'hB0);
    setReader(1, 0, 0);
    settle;
    checks++; if (writer_gnt_o !== 1'b1 || reader_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt: wr %b rd %b want 1/1", writer_gnt_o, reader_gnt_o); end
    nextCycle;
    setReader(0, 0, 0);
    checks++; if (reader_rdata_o !== 32'hD0) begin errors++; $display("[TB] FAIL b2b_pop: got %h want d0", reader_rdata_o); end
    setWriter(1, 0, 1, 4'hF, 0);
    nextCycle;
    setWriter(0, 0, 0, 0, 0);
    checks++; if (writer_rdata_o !== (32'h0000_0200 | IRQ_STATUS)) begin errors++; $display("[TB] FAIL b2b_status: got %h want %h", writer_rdata_o, 32'h0000_0200 | IRQ_STATUS); end
    setReader(1, 0, 0);
    nextCycle;
    checks++; if (reader_rdata_o !== 32'hD1) begin errors++; $display("[TB] FAIL b2b_pop2: got %h want d1", reader_rdata_o); end
    nextCycle;
    checks++; if (reader_rdata_o !== 32'hB0) begin errors++; $display("[TB] FAIL b2b_pop3: got %h want b0", reader_rdata_o); end
    setReader(0, 0, 0);
  endtask

  task automatic test_status;
    for (int i = 0; i < 3; i++) begin
      setWriter(1, 1, 0, 4'hF, 32'h10 + i);
      nextCycle;
    end
    setWriter(1, 0, 1, 4'hF, 0);
    setReader(1, 0, 1);
    nextCycle;
    setWriter(0, 0, 0, 0, 0);
    checks++; if (writer_rdata_o !== (32'h0000_0300 | IRQ_STATUS)) begin errors++; $display("[TB] FAIL status_wr: got %h want %h", writer_rdata_o, 32'h0000_0300 | IRQ_STATUS); end
    checks++; if (reader_rdata_o !== (32'h0000_0300 | IRQ_STATUS)) begin errors++; $display("[TB] FAIL status_rd: got %h want %h", reader_rdata_o, 32'h0000_0300 | IRQ_STATUS); end
    for (int i = 0; i < 3; i++) begin
      setReader(1, 0, 0);
      nextCycle;
      checks++; if (reader_rdata_o !== 32'h10 + i) begin errors++; $display("[TB] FAIL status_drain[%0d]: got %h want %h", i, reader_rdata_o, 32'h10 + i); end
    end
    setReader(0, 0, 0);
  endtask

  task automatic test_byte_enable;
    setWriter(1, 1, 0, 4'b0011, 32'hDEAD_BEEF);
    nextCycle;
    setWriter(0, 0, 0, 0, 0);
    setReader(1, 0, 0);
    nextCycle;
    setReader(0, 0, 0);
    checks++; if (reader_rdata_o !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL byte_enable: got %h want 0000beef", reader_rdata_o); end
  endtask

  task automatic test_misc_access;
    setWriter(1, 0, 0, 4'hF, 0);
    setReader(1, 1, 0);
    settle;
    checks++; if (writer_gnt_o !== 1'b1 || reader_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL misc_gnt: wr %b rd %b want 1/1", writer_gnt_o, reader_gnt_o); end
    nextCycle;
    checks++; if (writer_rvalid_o !== 1'b1 || writer_rdata_o !== 32'h0 || reader_rvalid_o !== 1'b1) begin errors++; $display("[TB] FAIL misc_rsp: wr %b/%h rd %b want 1/0 1", writer_rvalid_o, writer_rdata_o, reader_rvalid_o); end
    setWriter(1, 0, 2, 4'hF, 0);
    setReader(1, 1, 3);
    nextCycle;
    setWriter(1, 1, 3, 4'hF, 32'hFFFF_FFFF);
    checks++; if (writer_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL misc_reserved_rd: got %h want 0", writer_rdata_o); end
    nextCycle;
    setWriter(0, 0, 0, 0, 0);
    setReader(0, 0, 0);
    nextCycle;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("[TB] FAIL misc_no_effect: empty %b want 1", empty_o); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2; i++) begin
      setWriter(1, 1, 0, 4'hF, 32'hF0 + i);
      nextCycle;
    end
    setWriter(0, 0, 0, 0, 0);
    nextCycle;
    setReader(1, 0, 0);
    settle;
    checks++; if (reader_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_gnt: got %b want 1", reader_gnt_o); end
    rst_ni = 1'b0;
    nextCycle;
    setReader(0, 0, 0);
    checks++; if (reader_rvalid_o !== 1'b0 || reader_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_rvalid: rvalid %b rdata %h want 0/0", reader_rvalid_o, reader_rdata_o); end
    checks++; if (empty_o !== 1'b1 || irq_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags: empty %b irq %b want 1/0", empty_o, irq_o); end
    rst_ni = 1'b1;
    nextCycle;
    checks++; if (reader_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_late_rvalid: got %b want 0", reader_rvalid_o); end
    setReader(1, 0, 0);
    settle;
    checks++; if (reader_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_next_pop: got %b want 0", reader_gnt_o); end
    nextCycle;
    setReader(0, 0, 0);
    checks++; if (reader_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_next_rvalid: got %b want 0", reader_rvalid_o); end
  endtask

  // Run every scenario in order, then report the totals.
  initial begin
    test_reset;
    test_fill_and_stall;
    test_drain;
    test_full_contention;
    test_empty_contention;
    test_back_to_back;
    test_status;
    test_byte_enable;
    test_misc_access;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_obi_mailbox_fifo
